trace_commit_buf: RTL and testbench

Parametrised commit-trace block for the NPC difftest/trace path. It takes the per-instruction commit stream, keeps a shadow copy of the architectural register file, and buffers commit records in a ring FIFO. The simulation-side consumer drains the FIFO through a valid/ready port. Overflow is counted and flagged, never silently lost.

---
 rtl/trace_commit_buf_if.sv | 36 +++
 rtl/trace_commit_buf.sv | 139 +++++++++++++
 tb/tb_trace_commit_buf.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/trace_commit_buf_if.sv
// Commit-stream and trace-drain bundle for trace_commit_buf.
// The master side is the environment: it drives commits and consumes records.
// The slave side is the buffer: it accepts commits and presents the FIFO head.
interface trace_commit_buf_if #(
    parameter int XLEN = 64,
    parameter int RW   = 5,
    parameter int SEQW = 32
);
    // Per-instruction commit stream
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic            commit_wen;
    logic [RW-1:0]   commit_rd;
    logic [XLEN-1:0] commit_wdata;

    // Trace drain port (valid/ready)
    logic            out_valid;
    logic            out_ready;
    logic [SEQW-1:0] out_seq;
    logic [XLEN-1:0] out_pc;
    logic            out_wen;
    logic [RW-1:0]   out_rd;
    logic [XLEN-1:0] out_wdata;

    modport master (
        output commit_valid, commit_pc, commit_wen, commit_rd, commit_wdata,
        output out_ready,
        input  out_valid, out_seq, out_pc, out_wen, out_rd, out_wdata
    );

    modport slave (
        input  commit_valid, commit_pc, commit_wen, commit_rd, commit_wdata,
        input  out_ready,
        output out_valid, out_seq, out_pc, out_wen, out_rd, out_wdata
    );
endinterface

// File: rtl/trace_commit_buf.sv
// Commit-trace buffer: keeps a shadow copy of the architectural register file
// and queues one record per traced commit in a ring FIFO drained over
// valid/ready. Records that arrive while the FIFO is full are counted and
// flagged as overflow instead of being lost silently.
module trace_commit_buf #(
    parameter  int XLEN  = 64,
    parameter  int NREG  = 32,
    parameter  int DEPTH = 16,
    parameter  int SEQW  = 32,
    localparam int RW    = $clog2(NREG),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    trace_commit_buf_if.slave    bus,
    input  logic                 trace_en,
    output logic [PW:0]          count,
    output logic                 overflow,
    output logic [SEQW-1:0]      drop_cnt,
    input  logic                 ovf_clear,
    input  logic [RW-1:0]        dbg_raddr,
    output logic [XLEN-1:0]      dbg_rdata
);

    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [SEQW-1:0] seq;
        logic [XLEN-1:0] pc;
        logic            wen;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] wdata;
    } record_t;

    record_t         mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [SEQW-1:0] seq;
    logic [XLEN-1:0] rf [NREG];

    record_t rec_in;
    record_t head;
    logic    push_req;
    logic    pop;
    logic    full;
    logic    push_ok;
    logic    drop;

    assign push_req = bus.commit_valid & trace_en;
    assign pop      = bus.out_valid & bus.out_ready;
    assign full     = (count == FULL_CNT);
    // A full FIFO still takes the new record when the head leaves this cycle.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign rec_in.seq   = seq;
    assign rec_in.pc    = bus.commit_pc;
    assign rec_in.wen   = bus.commit_wen & (bus.commit_rd != '0);
    assign rec_in.rd    = bus.commit_rd;
    assign rec_in.wdata = bus.commit_wdata;

    // Head fields are forced to zero whenever there is nothing to present;
    // out_valid comes straight from the async-reset count, so it drops with reset.
    assign head          = mem[rptr];
    assign bus.out_valid = (count != '0);
    assign bus.out_seq   = bus.out_valid ? head.seq   : '0;
    assign bus.out_pc    = bus.out_valid ? head.pc    : '0;
    assign bus.out_wen   = bus.out_valid ? head.wen   : 1'b0;
    assign bus.out_rd    = bus.out_valid ? head.rd    : '0;
    assign bus.out_wdata = bus.out_valid ? head.wdata : '0;

    // FIFO storage write.
    // NOTE: the record array has no reset; stale entries are never visible
    // because every head field is gated by out_valid.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wptr] <= rec_in;
        end
    end

    // Pointers, occupancy, sequence counter and overflow bookkeeping.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            seq      <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (bus.commit_valid) begin
                seq <= seq + SEQW'(1);
            end
            if (push_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear restarts the tally at one.
            if (drop) begin
                overflow <= 1'b1;
                if (ovf_clear) begin
                    drop_cnt <= SEQW'(1);
                end else if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + SEQW'(1);
                end
            end else if (ovf_clear) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

    // Shadow register file update and registered debug read (pre-write value).
    // NOTE: the shadow file is reset because software reads every entry
    // through the debug port and expects zeros after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            dbg_rdata <= '0;
        end else begin
            if (bus.commit_valid && bus.commit_wen && (bus.commit_rd != '0)) begin
                rf[bus.commit_rd] <= bus.commit_wdata;
            end
            dbg_rdata <= rf[dbg_raddr];
        end
    end

endmodule

// File: tb/tb_trace_commit_buf.sv
// Directed self-checking bench for trace_commit_buf with hand-computed
// expectations. Inputs change and outputs are sampled 1 ns after each
// rising edge.
module tb_trace_commit_buf;

    logic        clock;
    logic        reset;
    logic        trace_en;
    logic [4:0]  count;
    logic        overflow;
    logic [31:0] drop_cnt;
    logic        ovf_clear;
    logic [4:0]  dbg_raddr;
    logic [63:0] dbg_rdata;

    int checks = 0;
    int errors = 0;

    trace_commit_buf_if #(.XLEN(64), .RW(5), .SEQW(32)) bus ();

    trace_commit_buf #(
        .XLEN (64),
        .NREG (32),
        .DEPTH(16),
        .SEQW (32)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .trace_en (trace_en),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .ovf_clear(ovf_clear),
        .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbg_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic commit(input logic [63:0] pc, input logic wen, input logic [4:0] rd,
                          input logic [63:0] wdata);
        bus.commit_valid = 1'b1;
        bus.commit_pc    = pc;
        bus.commit_wen   = wen;
        bus.commit_rd    = rd;
        bus.commit_wdata = wdata;
        step();
        bus.commit_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.commit_valid = 1'b0;
        bus.out_ready    = 1'b0;
        ovf_clear        = 1'b0;
        trace_en         = 1'b1;
        reset            = 1'b1;
        #12;
        reset = 1'b0;
        step();
    endtask

    initial begin
        bus.commit_valid = 1'b0;
        bus.commit_pc    = '0;
        bus.commit_wen   = 1'b0;
        bus.commit_rd    = '0;
        bus.commit_wdata = '0;
        bus.out_ready    = 1'b0;
        trace_en         = 1'b1;
        ovf_clear        = 1'b0;
        dbg_raddr        = '0;
        reset            = 1'b0;
        #2;
        do_reset();

        // Reset state
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_count",     64'(count),         64'd0);
        check("rst_overflow",  64'(overflow),      64'd0);
        check("rst_drop_cnt",  64'(drop_cnt),      64'd0);
        check("rst_dbg_rdata", dbg_rdata,          64'd0);
        check("rst_out_pc",    bus.out_pc,         64'd0);

        // Three commits drained on the fly
        bus.out_ready = 1'b1;
        commit(64'h8000_0000, 1'b1, 5'd1, 64'h11);
        check("t1_valid0", 64'(bus.out_valid), 64'd1);
        check("t1_seq0",   64'(bus.out_seq),   64'd0);
        check("t1_pc0",    bus.out_pc,         64'h8000_0000);
        check("t1_wen0",   64'(bus.out_wen),   64'd1);
        check("t1_rd0",    64'(bus.out_rd),    64'd1);
        check("t1_wdata0", bus.out_wdata,      64'h11);
        commit(64'h8000_0004, 1'b1, 5'd2, 64'h22);
        check("t1_seq1",   64'(bus.out_seq),   64'd1);
        check("t1_pc1",    bus.out_pc,         64'h8000_0004);
        check("t1_wdata1", bus.out_wdata,      64'h22);
        commit(64'h8000_0008, 1'b1, 5'd0, 64'h33);
        check("t1_seq2",   64'(bus.out_seq),   64'd2);
        check("t1_wen2",   64'(bus.out_wen),   64'd0);
        check("t1_rd2",    64'(bus.out_rd),    64'd0);
        check("t1_wdata2", bus.out_wdata,      64'h33);
        dbg_raddr = 5'd1;
        step();
        check("t1_empty_valid", 64'(bus.out_valid), 64'd0);
        check("t1_empty_count", 64'(count),         64'd0);
        check("t1_empty_pc",    bus.out_pc,         64'd0);
        check("t1_dbg_x1",      dbg_rdata,          64'h11);
        dbg_raddr = 5'd0;
        step();
        check("t1_dbg_x0",      dbg_rdata,          64'd0);

        // Overflow: 20 commits into a 16-deep FIFO with no consumer
        do_reset();
        for (int i = 0; i < 20; i++) begin
            commit(64'h1000 + 64'(4 * i), 1'b1, 5'((i % 31) + 1), 64'(i));
        end
        check("t2_count",    64'(count),         64'd16);
        check("t2_overflow", 64'(overflow),      64'd1);
        check("t2_drop_cnt", 64'(drop_cnt),      64'd4);
        check("t2_head_seq", 64'(bus.out_seq),   64'd0);
        check("t2_head_pc",  bus.out_pc,         64'h1000);

        // Full FIFO with push and pop in the same cycle: accepted, seq 20
        bus.out_ready = 1'b1;
        commit(64'h2000, 1'b1, 5'd7, 64'h77);
        check("t3_count",    64'(count),       64'd16);
        check("t3_drop_cnt", 64'(drop_cnt),    64'd4);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t3_valid_%0d", k), 64'(bus.out_valid), 64'd1);
            check($sformatf("t3_seq_%0d", k), 64'(bus.out_seq),
                  (k < 15) ? 64'(k + 1) : 64'd20);
            check($sformatf("t3_pc_%0d", k), bus.out_pc,
                  (k < 15) ? 64'h1000 + 64'(4 * (k + 1)) : 64'h2000);
            step();
        end
        check("t3_drained_valid", 64'(bus.out_valid), 64'd0);
        check("t3_drained_count", 64'(count),         64'd0);

        // Untraced commits still update the shadow file and the sequence
        do_reset();
        trace_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            commit(64'h3000 + 64'(4 * i), 1'b1, 5'd5, 64'hAA + 64'(i));
        end
        check("t4_valid", 64'(bus.out_valid), 64'd0);
        check("t4_count", 64'(count),         64'd0);
        dbg_raddr = 5'd5;
        step();
        check("t4_dbg_x5", dbg_rdata, 64'hAE);
        trace_en = 1'b1;
        commit(64'h4000, 1'b1, 5'd5, 64'hBB);
        check("t4_dbg_prewrite", dbg_rdata,          64'hAE);
        check("t4_valid_traced", 64'(bus.out_valid), 64'd1);
        check("t4_seq",          64'(bus.out_seq),   64'd5);
        check("t4_wdata",        bus.out_wdata,      64'hBB);
        step();
        check("t4_dbg_postwrite", dbg_rdata, 64'hBB);
        bus.out_ready = 1'b1;
        step();
        check("t4_drained", 64'(count), 64'd0);

        // Clear coinciding with a drop, then clear alone
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            commit(64'h5000 + 64'(4 * i), 1'b0, 5'd0, 64'd0);
        end
        check("t5_full_count", 64'(count),    64'd16);
        check("t5_no_ovf",     64'(overflow), 64'd0);
        commit(64'h5100, 1'b0, 5'd0, 64'd0);
        check("t5_drop1_ovf", 64'(overflow), 64'd1);
        check("t5_drop1_cnt", 64'(drop_cnt), 64'd1);
        ovf_clear = 1'b1;
        commit(64'h5104, 1'b0, 5'd0, 64'd0);
        check("t5_clrdrop_ovf", 64'(overflow), 64'd1);
        check("t5_clrdrop_cnt", 64'(drop_cnt), 64'd1);
        step();
        ovf_clear = 1'b0;
        check("t5_clr_ovf",   64'(overflow), 64'd0);
        check("t5_clr_cnt",   64'(drop_cnt), 64'd0);
        check("t5_clr_count", 64'(count),    64'd16);

        // Asynchronous reset with data buffered
        do_reset();
        for (int i = 0; i < 7; i++) begin
            commit(64'h6000 + 64'(4 * i), 1'b1, 5'(i + 1), 64'h100 + 64'(i));
        end
        dbg_raddr = 5'd3;
        step();
        check("t6_pre_count", 64'(count),         64'd7);
        check("t6_pre_valid", 64'(bus.out_valid), 64'd1);
        check("t6_pre_dbg",   dbg_rdata,          64'h102);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_valid", 64'(bus.out_valid), 64'd0);
        check("t6_async_count", 64'(count),         64'd0);
        check("t6_async_seq",   64'(bus.out_seq),   64'd0);
        check("t6_async_dbg",   dbg_rdata,          64'd0);
        #8;
        reset = 1'b0;
        step();
        check("t6_post_count", 64'(count), 64'd0);
        for (int r = 0; r < 32; r++) begin
            dbg_raddr = 5'(r);
            step();
            check($sformatf("t6_rf_%0d", r), dbg_rdata, 64'd0);
        end
        commit(64'h7000, 1'b1, 5'd1, 64'h1);
        check("t6_seq_restart", 64'(bus.out_seq), 64'd0);
        check("t6_count_one",   64'(count),       64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
